wb_trace_fifo: RTL and testbench

//  Captures every register write-back event retired by the OpenMIPS core
//  (write-back stage outputs) and buffers it in a FIFO.

---
 rtl/wb_trace_fifo.sv | 153 +++++++++++++++
 tb/tb_wb_trace_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: first-word-fall-through trace buffer for write-back events.
// Each captured register write is stamped with a running sequence number and
// buffered until a consumer pops it over a valid/ready handshake. Events that
// arrive while the buffer is full are dropped, counted, and flagged stickily.
module wb_trace_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SEQ_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     trace_en_i,
  input  logic                     wb_wreg_i,
  input  logic [REG_AW-1:0]        wb_wd_i,
  input  logic [DATA_W-1:0]        wb_wdata_i,
  input  logic [DATA_W-1:0]        wb_pc_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [DATA_W-1:0]        trace_pc_o,
  output logic [REG_AW-1:0]        trace_wd_o,
  output logic [DATA_W-1:0]        trace_wdata_o,
  output logic [SEQ_W-1:0]         trace_seq_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o,
  output logic [SEQ_W-1:0]         drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage; contents are only observable through the valid-gated head.
  logic [DATA_W-1:0] pc_mem_q    [DEPTH];
  logic [REG_AW-1:0] wd_mem_q    [DEPTH];
  logic [DATA_W-1:0] wdata_mem_q [DEPTH];
  logic [SEQ_W-1:0]  seq_mem_q   [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  logic capture;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // Event qualification and handshake decode.
  always_comb begin
    capture = wb_wreg_i & trace_en_i & (wb_wd_i != '0);
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    pop     = ~empty & trace_ready_i;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    push    = capture & (~full | pop);
    drop    = capture & full & ~pop;
  end

  // Next-state for pointers, occupancy, sequence and drop accounting.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;

    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      seq_d      = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // Dropped events still consume a sequence number so gaps reveal them.
      if (capture) begin
        seq_d = seq_q + SEQ_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + SEQ_W'(1);
        end
      end
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry write; a push during clear is harmless since occupancy resets.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= wb_pc_i;
      wd_mem_q[wr_ptr_q]    <= wb_wd_i;
      wdata_mem_q[wr_ptr_q] <= wb_wdata_i;
      seq_mem_q[wr_ptr_q]   <= seq_q;
    end
  end

  // Head presentation, forced to zero whenever nothing is buffered.
  always_comb begin
    trace_valid_o = ~empty;
    trace_pc_o    = '0;
    trace_wd_o    = '0;
    trace_wdata_o = '0;
    trace_seq_o   = '0;
    if (!empty) begin
      trace_pc_o    = pc_mem_q[rd_ptr_q];
      trace_wd_o    = wd_mem_q[rd_ptr_q];
      trace_wdata_o = wdata_mem_q[rd_ptr_q];
      trace_seq_o   = seq_mem_q[rd_ptr_q];
    end
  end

  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Testbench for wb_trace_fifo: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the trace buffer.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        clear_i;
  logic        trace_en_i;
  logic        wb_wreg_i;
  logic [4:0]  wb_wd_i;
  logic [31:0] wb_wdata_i;
  logic [31:0] wb_pc_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_pc_o;
  logic [4:0]  trace_wd_o;
  logic [31:0] trace_wdata_o;
  logic [15:0] trace_seq_o;
  logic [4:0]  fifo_count_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  wb_trace_fifo #(
    .DEPTH (16),
    .DATA_W(32),
    .REG_AW(5),
    .SEQ_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_i),
    .trace_en_i   (trace_en_i),
    .wb_wreg_i    (wb_wreg_i),
    .wb_wd_i      (wb_wd_i),
    .wb_wdata_i   (wb_wdata_i),
    .wb_pc_i      (wb_pc_i),
    .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i),
    .trace_pc_o   (trace_pc_o),
    .trace_wd_o   (trace_wd_o),
    .trace_wdata_o(trace_wdata_o),
    .trace_seq_o  (trace_seq_o),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wd;
    logic [31:0] data;
    logic [15:0] seq;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_seq;
  logic [15:0] m_drop;
  logic        m_ovf;
  int          errors;
  int          checks;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_seq  = '0;
    m_drop = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_all();
    check("valid", 64'(trace_valid_o), 64'(q.size() > 0));
    check("count", 64'(fifo_count_o), 64'(q.size()));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
    if (q.size() > 0) begin
      check("head_pc", 64'(trace_pc_o), 64'(q[0].pc));
      check("head_wd", 64'(trace_wd_o), 64'(q[0].wd));
      check("head_data", 64'(trace_wdata_o), 64'(q[0].data));
      check("head_seq", 64'(trace_seq_o), 64'(q[0].seq));
    end else begin
      check("idle_pc", 64'(trace_pc_o), 64'd0);
      check("idle_wd", 64'(trace_wd_o), 64'd0);
      check("idle_data", 64'(trace_wdata_o), 64'd0);
      check("idle_seq", 64'(trace_seq_o), 64'd0);
    end
  endtask

  // One clock edge: the model consumes the currently driven inputs, then the
  // DUT is sampled 1 time unit after the edge.
  task automatic tick();
    bit   cap;
    bit   popd;
    ent_t e;
    cap  = wb_wreg_i && trace_en_i && (wb_wd_i != 5'd0);
    popd = (q.size() > 0) && trace_ready_i;
    if (clear_i) begin
      model_reset();
    end else begin
      if (popd) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) begin
          e.pc = wb_pc_i; e.wd = wb_wd_i; e.data = wb_wdata_i; e.seq = m_seq;
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        m_seq = m_seq + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] data,
                       input logic [31:0] pc, input logic ready);
    wb_wreg_i     = wreg;
    wb_wd_i       = wd;
    wb_wdata_i    = data;
    wb_pc_i       = pc;
    trace_ready_i = ready;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 5'($urandom_range(31, 1)), $urandom, $urandom, 1'b0);
      tick();
    end
  endtask

  task automatic do_clear();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_reset();
    rst = 1'b0;
    clear_i = 1'b0;
    trace_en_i = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

    // Reset held with random write-back activity.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'($urandom), $urandom, $urandom, 1'($urandom));
      @(posedge clk);
      #1;
      check_all();
    end
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);

    // Single event, held until ready.
    drive(1'b1, 5'd5, 32'h1234, 32'h10, 1'b0);
    tick();
    check("single_seq", 64'(trace_seq_o), 64'd0);
    check("single_pc", 64'(trace_pc_o), 64'h10);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("single_hold", 64'(trace_wdata_o), 64'h1234);
    trace_ready_i = 1'b1;
    tick();

    // Writes to $0 are ignored.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h20, 1'b1);
    tick();
    check("r0_count", 64'(fifo_count_o), 64'd0);
    drive(1'b1, 5'd7, 32'h77, 32'h24, 1'b0);
    tick();
    check("r0_seq", 64'(trace_seq_o), 64'd1);

    // Overflow: 18 events into an empty FIFO with ready low.
    do_clear();
    for (int i = 1; i <= 18; i++) begin
      drive(1'b1, 5'(i), 32'(i * 3), 32'(i * 4), 1'b0);
      tick();
    end
    check("ovf_count", 64'(fifo_count_o), 64'd16);
    check("ovf_flag", 64'(overflow_o), 64'd1);
    check("ovf_drops", 64'(drop_cnt_o), 64'd2);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check("drain_seq", 64'(trace_seq_o), 64'(i));
      tick();
    end
    drive(1'b1, 5'd9, 32'h99, 32'h90, 1'b0);
    tick();
    check("post_ovf_seq", 64'(trace_seq_o), 64'd18);

    // Full FIFO with simultaneous push and pop.
    fill(15);
    check("full_count", 64'(fifo_count_o), 64'd16);
    drive(1'b1, 5'd31, 32'hDEAD_BEEF, 32'hCAFE, 1'b1);
    tick();
    check("pp_count", 64'(fifo_count_o), 64'd16);
    check("pp_drops", 64'(drop_cnt_o), 64'd2);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("pp_last", 64'(trace_wdata_o), 64'hDEAD_BEEF);
    tick();

    // Capture disabled: buffered entries still drain, new ones are blocked.
    fill(4);
    trace_en_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd3, $urandom, $urandom, 1'b1);
      tick();
    end
    check("en_off_count", 64'(fifo_count_o), 64'd0);
    trace_en_i = 1'b1;

    // Mid-stream clear, with push and pop requested in the same cycle.
    fill(5);
    drive(1'b1, 5'd4, 32'h44, 32'h40, 1'b1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_count", 64'(fifo_count_o), 64'd0);
    drive(1'b1, 5'd6, 32'h66, 32'h60, 1'b0);
    tick();
    check("clr_seq", 64'(trace_seq_o), 64'd0);

    // Mid-stream asynchronous reset pulse between edges.
    fill(4);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 64'(trace_valid_o), 64'd0);
    check("arst_count", 64'(fifo_count_o), 64'd0);
    #1 rst = 1'b1;
    drive(1'b1, 5'd8, 32'h88, 32'h80, 1'b0);
    tick();
    check("arst_seq", 64'(trace_seq_o), 64'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(3, 0) != 0), 5'($urandom_range(31, 0)), $urandom, $urandom,
            1'($urandom_range(2, 0) == 0));
      trace_en_i = 1'($urandom_range(9, 0) != 0);
      clear_i    = 1'($urandom_range(99, 0) == 0);
      tick();
    end
    clear_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
